// File: rtl/cu_pkg.sv
// Shared control-unit definitions: opcodes, FSM encodings, control-word layout,
// condition codes and status flag positions.
package cu_pkg;

  localparam logic [7:0] OP_CBZ   = 8'hB4;
  localparam logic [7:0] OP_CBNZ  = 8'hB5;
  localparam logic [7:0] OP_BCOND = 8'h54;

  // ST_ERR is an internal sub-state; it reports IDLE in the control word.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_TEST    = 2'b01,
    ST_RESOLVE = 2'b10,
    ST_ERR     = 2'b11
  } state_e;

  localparam logic [1:0] PC_INC    = 2'b01;
  localparam logic [1:0] PC_OFFSET = 2'b11;
  localparam logic [4:0] ALU_PASS  = 5'b00100;

  localparam int CW_WIDTH = 33;
  localparam int IMM_LSB  = 5;
  localparam int IMM_W    = 19;

  typedef struct packed {
    logic       alu_en;
    logic       alu_b_sel;
    logic [4:0] alu_fs;
    logic       rf_b_en;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] da;
    logic       rf_wr;
    logic       ram_en;
    logic       ram_wr;
    logic       pc_en;
    logic [1:0] pc_fs;
    logic       pc_in_sel;
    logic       status_load;
    logic [1:0] next_state;
  } cw_t;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_C = 2;
  localparam int ST_V = 3;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational B.cond evaluator: condition code plus NZCV flags -> taken.
module branch_cond_eval
  import cu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic z, n, c, v, gt, hi;

  assign z  = flags[ST_Z];
  assign n  = flags[ST_N];
  assign c  = flags[ST_C];
  assign v  = flags[ST_V];
  assign hi = c & ~z;
  assign gt = ~z & (n == v);

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ: taken = z;
      CC_NE: taken = ~z;
      CC_CS: taken = c;
      CC_CC: taken = ~c;
      CC_MI: taken = n;
      CC_PL: taken = ~n;
      CC_VS: taken = v;
      CC_VC: taken = ~v;
      CC_HI: taken = hi;
      CC_LS: taken = ~hi;
      CC_GE: taken = (n == v);
      CC_LT: taken = (n != v);
      CC_GT: taken = gt;
      CC_LE: taken = ~gt;
      CC_AL: taken = 1'b1;
      CC_NV: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_branch_sequencer.sv
// Conditional-branch sequencer: CBZ/CBNZ in two cycles (test, resolve),
// B.cond in one; emits control word, sign-extended imm19 and perf counters.
module cond_branch_sequencer
  import cu_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int COUNT_WIDTH  = 16,
  parameter int ZERO_REG     = 31,
  parameter int ENABLE_BCOND = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            instruction,
  input  logic [4:0]             status,
  output logic                   busy,
  output logic                   done,
  output logic                   branch_taken,
  output logic                   illegal,
  output logic [CW_WIDTH-1:0]    controlword,
  output logic [DATA_WIDTH-1:0]  constant,
  output logic [COUNT_WIDTH-1:0] taken_count,
  output logic [COUNT_WIDTH-1:0] not_taken_count
);

  state_e                 state_q, state_d;
  logic [31:0]            instr_q, instr_d;
  logic [COUNT_WIDTH-1:0] taken_q, not_taken_q;
  logic [IMM_W-1:0]       imm;
  logic                   bcond_taken;
  logic                   unused_status;
  cw_t                    cw;

  assign unused_status = status[4];

  branch_cond_eval u_cond (
    .cond  (instr_q[3:0]),
    .flags (status[3:0]),
    .taken (bcond_taken)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      taken_q     <= '0;
      not_taken_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      if (done && !illegal) begin
        if (branch_taken) begin
          if (taken_q != '1) taken_q <= taken_q + COUNT_WIDTH'(1);
        end else begin
          if (not_taken_q != '1) not_taken_q <= not_taken_q + COUNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    cw           = '0;
    busy         = 1'b0;
    done         = 1'b0;
    branch_taken = 1'b0;
    illegal      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          instr_d = instruction;
          case (instruction[31:24])
            OP_CBZ, OP_CBNZ: state_d = ST_TEST;
            OP_BCOND:        state_d = (ENABLE_BCOND != 0) ? ST_RESOLVE : ST_ERR;
            default:         state_d = ST_ERR;
          endcase
        end
      end
      ST_TEST: begin
        busy           = 1'b1;
        state_d        = ST_RESOLVE;
        cw.alu_fs      = ALU_PASS;
        cw.sa          = instr_q[4:0];
        cw.sb          = 5'(ZERO_REG);
        cw.status_load = 1'b1;
        cw.next_state  = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
        // CBZ has bit 24 clear and CBNZ set, so XOR with Z yields taken for both.
        if (instr_q[31:24] == OP_BCOND) branch_taken = bcond_taken;
        else                            branch_taken = instr_q[24] ^ status[ST_Z];
        cw.pc_en      = 1'b1;
        cw.pc_in_sel  = 1'b1;
        cw.pc_fs      = branch_taken ? PC_OFFSET : PC_INC;
        cw.next_state = ST_IDLE;
      end
      ST_ERR: begin
        done          = 1'b1;
        illegal       = 1'b1;
        state_d       = ST_IDLE;
        cw.pc_en      = 1'b1;
        cw.pc_fs      = PC_INC;
        cw.next_state = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imm             = instr_q[IMM_LSB +: IMM_W];
  assign constant        = {{(DATA_WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  assign controlword     = cw;
  assign taken_count     = taken_q;
  assign not_taken_count = not_taken_q;

endmodule

// File: tb/tb_cond_branch_sequencer.sv
// Directed bench for cond_branch_sequencer: default instance plus a
// COUNT_WIDTH=2 instance for saturation.
module tb_cond_branch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start, start_s;
  logic [31:0] instruction;
  logic [4:0]  status;

  logic        busy, done, taken, illegal;
  logic [32:0] cw;
  logic [63:0] constant;
  logic [15:0] tk_cnt, ntk_cnt;

  logic        busy_s, done_s, taken_s, illegal_s;
  logic [32:0] cw_s;
  logic [63:0] constant_s;
  logic [1:0]  tk_cnt_s, ntk_cnt_s;

  int errors = 0;
  int checks = 0;
  int exp_tk = 0;
  int exp_ntk = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cond_branch_sequencer u_dut (
    .clock(clk), .reset(rst_n), .start(start), .instruction(instruction),
    .status(status), .busy(busy), .done(done), .branch_taken(taken),
    .illegal(illegal), .controlword(cw), .constant(constant),
    .taken_count(tk_cnt), .not_taken_count(ntk_cnt)
  );

  cond_branch_sequencer #(.COUNT_WIDTH(2)) u_sat (
    .clock(clk), .reset(rst_n), .start(start_s), .instruction(instruction),
    .status(status), .busy(busy_s), .done(done_s), .branch_taken(taken_s),
    .illegal(illegal_s), .controlword(cw_s), .constant(constant_s),
    .taken_count(tk_cnt_s), .not_taken_count(ntk_cnt_s)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] mk_cw(input logic [4:0] alu_fs, input logic [4:0] sa,
                                        input logic [4:0] sb, input logic pc_en,
                                        input logic [1:0] pc_fs, input logic pc_in_sel,
                                        input logic status_load, input logic [1:0] ns);
    return {1'b0, 1'b0, alu_fs, 1'b0, sa, sb, 5'd0, 1'b0, 1'b0, 1'b0,
            pc_en, pc_fs, pc_in_sel, status_load, ns};
  endfunction

  initial begin
    logic [32:0] w_test, w_tk, w_ntk, w_nop;
    logic        e;
    w_test = mk_cw(5'b00100, 5'd3, 5'd31, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10);
    w_tk   = mk_cw(5'd0, 5'd0, 5'd0, 1'b1, 2'b11, 1'b1, 1'b0, 2'b00);
    w_ntk  = mk_cw(5'd0, 5'd0, 5'd0, 1'b1, 2'b01, 1'b1, 1'b0, 2'b00);
    w_nop  = mk_cw(5'd0, 5'd0, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00);

    rst_n = 1'b0; start = 1'b0; start_s = 1'b0; instruction = '0; status = '0;
    #2;
    chk("rst_cw", {31'd0, cw}, 64'd0);
    chk("rst_flags", {60'd0, busy, done, taken, illegal}, 64'd0);
    chk("rst_const", constant, 64'd0);
    chk("rst_cnt", {32'd0, tk_cnt, ntk_cnt}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // CBZ X3, imm19=0x10, Z=1 in RESOLVE
    instruction = {8'hB4, 19'h00010, 5'd3}; start = 1'b1;
    tick();
    start = 1'b0; status = 5'b00001;
    chk("cbz_test_cw", {31'd0, cw}, {31'd0, w_test});
    chk("cbz_test_busy_done", {62'd0, busy, done}, 64'b10);
    tick();
    chk("cbz_res_cw", {31'd0, cw}, {31'd0, w_tk});
    chk("cbz_res_done_taken", {61'd0, done, taken, illegal}, 64'b110);
    chk("cbz_const", constant, 64'h10);
    tick();
    exp_tk++;
    chk("cbz_tk_cnt", {48'd0, tk_cnt}, 64'(exp_tk));
    chk("cbz_idle_busy", {62'd0, busy, done}, 64'd0);

    // CBNZ X7, imm19=all ones, Z=1 -> not taken
    instruction = {8'hB5, 19'h7FFFF, 5'd7}; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("cbnz_res_cw", {31'd0, cw}, {31'd0, w_ntk});
    chk("cbnz_res_done_taken", {62'd0, done, taken}, 64'b10);
    chk("cbnz_const", constant, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    exp_ntk++;
    chk("cbnz_ntk_cnt", {48'd0, ntk_cnt}, 64'(exp_ntk));

    // B.GT over all NZCV; start issued the cycle after each done
    for (int i = 0; i < 16; i++) begin
      logic n, z, c, v;
      n = i[3]; z = i[2]; c = i[1]; v = i[0];
      e = !z && (n == v);
      instruction = {8'h54, 19'h00005, 5'h0C};
      status = {1'b0, v, c, n, z};
      start = 1'b1;
      tick();
      start = 1'b0;
      chk($sformatf("bgt_%0d_done", i), {62'd0, busy, done}, 64'b11);
      chk($sformatf("bgt_%0d_taken", i), {63'd0, taken}, {63'd0, e});
      chk($sformatf("bgt_%0d_cw", i), {31'd0, cw}, {31'd0, (e ? w_tk : w_ntk)});
      if (e) exp_tk++; else exp_ntk++;
      tick();
    end
    chk("bgt_tk_cnt", {48'd0, tk_cnt}, 64'(exp_tk));
    chk("bgt_ntk_cnt", {48'd0, ntk_cnt}, 64'(exp_ntk));

    // Illegal opcode; start during the ERR cycle must be ignored
    instruction = 32'h9100_0040; start = 1'b1;
    tick();
    instruction = {8'hB4, 19'h00123, 5'd1};
    chk("ill_flags", {60'd0, busy, done, taken, illegal}, 64'b0101);
    chk("ill_cw", {31'd0, cw}, {31'd0, w_nop});
    chk("ill_const", constant, 64'd2);
    tick();
    start = 1'b0;
    chk("ill_err_start_ignored", {62'd0, busy, done}, 64'd0);
    chk("ill_const_held", constant, 64'd2);
    chk("ill_cnt", {32'd0, tk_cnt, ntk_cnt}, {32'd0, 16'(exp_tk), 16'(exp_ntk)});

    // start pulses while busy are ignored
    instruction = {8'hB4, 19'h00020, 5'd3}; status = 5'b00000; start = 1'b1;
    tick();
    instruction = {8'h54, 19'h00777, 5'h0E};
    tick();
    chk("busy_start_cw", {31'd0, cw}, {31'd0, w_ntk});
    chk("busy_start_const", constant, 64'h20);
    start = 1'b0;
    tick();
    exp_ntk++;
    chk("busy_start_idle", {62'd0, busy, done}, 64'd0);
    chk("busy_start_ntk", {48'd0, ntk_cnt}, 64'(exp_ntk));

    // Saturation on the 2-bit-counter instance with B.AL
    instruction = {8'h54, 19'h0, 5'h0E};
    for (int k = 1; k <= 5; k++) begin
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      tick();
      chk($sformatf("sat_%0d", k), {62'd0, tk_cnt_s}, 64'((k > 3) ? 3 : k));
    end

    // Reset during TEST aborts immediately
    instruction = {8'hB4, 19'h00010, 5'd3}; start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_in_test", {31'd0, cw}, {31'd0, w_test});
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cw", {31'd0, cw}, 64'd0);
    chk("abort_flags", {60'd0, busy, done, taken, illegal}, 64'd0);
    chk("abort_cnt", {32'd0, tk_cnt, ntk_cnt}, 64'd0);
    chk("abort_const", constant, 64'd0);
    tick();
    chk("abort_no_done", {62'd0, busy, done}, 64'd0);
    rst_n = 1'b1;
    instruction = {8'h54, 19'h0, 5'h0E}; start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_rst_done", {62'd0, done, taken}, 64'b11);
    tick();
    chk("post_rst_tk", {48'd0, tk_cnt}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
